// File: rtl/uart_tx_cfg_pkg.sv
// rtl/uart_tx_cfg_pkg.sv - shared types, constants and parity helper for the UART transmitter
//
// Purpose: FSM state encoding, parity mode constants (taken from UART.vh)
// and the parity computation used when a word is popped from the FIFO.
package uart_tx_cfg_pkg;

`include "UART.vh"

  localparam int DEFAULT_CLKS_PER_BIT = `BAUD6M_CLK24M;
  localparam int PARITY_NONE          = `UART_PARITY_NONE;
  localparam int PARITY_EVEN          = `UART_PARITY_EVEN;
  localparam int PARITY_ODD           = `UART_PARITY_ODD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Data is zero-extended to 9 bits by the caller; the extra zeros do not
  // change the XOR, so one helper covers every legal DATA_BITS.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/UART.vh
// rtl/UART.vh - shared UART baud constants and parity mode encodings
`ifndef UART_VH
`define UART_VH

// Clock cycles per serial bit for common clock/baud pairs.
`define BAUD6M_CLK24M      4
`define BAUD3M_CLK24M      8
`define BAUD115200_CLK24M  208

// Parity mode encodings for the PARITY_MODE parameter.
`define UART_PARITY_NONE   0
`define UART_PARITY_EVEN   1
`define UART_PARITY_ODD    2

`endif

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO holding words queued for transmission
//
// Purpose: power-of-two deep FIFO with fall-through read data.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset (clears pointers and count)
//   push_i   - write wdata_i this edge (ignored when full)
//   wdata_i  - word to write
//   pop_i    - discard the head word this edge (ignored when empty)
//   rdata_o  - head word, valid whenever empty_o is 0
//   count_o  - number of words held
//   full_o   - count_o == DEPTH
//   empty_o  - count_o == 0
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so plain pointer increment wraps correctly.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with transmit FIFO
//
// Purpose: accepts words on a valid/ready handshake into a FIFO and sends
// them as UART frames: START, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. Frames follow each other with no idle gap.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   in_data    - word to transmit
//   in_valid   - in_data presented this cycle
//   in_ready   - FIFO can accept a word this cycle
//   tx         - serial line, idle high
//   tx_busy    - a frame is on the line
//   fifo_count - words held in the FIFO
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_EVEN,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int             CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic           HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic           ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  ready_q;

  logic                  push, pop;
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [8:0]            word_ext;
  logic                  bit_end;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ready_q holds in_ready low during reset and through the release edge.
  assign in_ready = ready_q & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    word_ext = '0;
    word_ext[DATA_BITS-1:0] = fifo_rdata;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(word_ext, ODD_PARITY);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next START when more words wait.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              par_d   = parity_bit(word_ext, ODD_PARITY);
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= 1'b1;
    end
  end

endmodule
